// File: rtl/simmem_pkg.sv
// Shared types and default widths for the simulated-memory release scheduler.
// Slot state encoding lives here so the top and the slot agree on it.
package simmem_pkg;

    localparam int IDWidthDef    = 8;
    localparam int DelayWidthDef = 8;
    localparam int NumSlotsDef   = 16;

    typedef enum logic [1:0] {
        SLOT_FREE,
        SLOT_COUNTING,
        SLOT_EXPIRED
    } slot_state_e;

endpackage

// File: rtl/simmem_release_scheduler_if.sv
// Delay-request and bank-release handshake bundle.
// The master side issues requests and reports releases; the scheduler is the slave.
interface simmem_release_scheduler_if #(
    parameter int IDWidth    = simmem_pkg::IDWidthDef,
    parameter int DelayWidth = simmem_pkg::DelayWidthDef
);

    logic                  delay_valid;
    logic                  delay_ready;
    logic [IDWidth-1:0]    delay_id;
    logic [DelayWidth-1:0] delay_cycles;
    logic                  released_valid;
    logic [IDWidth-1:0]    released_id;

    modport master (
        output delay_valid,
        input  delay_ready,
        output delay_id,
        output delay_cycles,
        output released_valid,
        output released_id
    );

    modport slave (
        input  delay_valid,
        output delay_ready,
        input  delay_id,
        input  delay_cycles,
        input  released_valid,
        input  released_id
    );

endinterface

// File: rtl/simmem_release_slot.sv
// One delay slot: holds an ID and counts its delay down to expiry.
// An expired slot waits for a matching bank release before going free again.
module simmem_release_slot
    import simmem_pkg::*;
#(
    parameter int IDWidth    = IDWidthDef,
    parameter int DelayWidth = DelayWidthDef
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  alloc_i,
    input  logic                  retire_i,
    input  logic [IDWidth-1:0]    id_i,
    input  logic [DelayWidth-1:0] cycles_i,
    output logic                  is_free_o,
    output logic                  is_expired_o,
    output logic [IDWidth-1:0]    id_o
);

    slot_state_e           state_q, state_d;
    logic [DelayWidth-1:0] cnt_q, cnt_d;
    logic [IDWidth-1:0]    id_q, id_d;

    // Slot state, countdown and ID registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SLOT_FREE;
            cnt_q   <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
        end
    end

    // Next-state: allocate, count down without wrapping, retire.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        unique case (state_q)
            SLOT_FREE: begin
                if (alloc_i) begin
                    id_d  = id_i;
                    cnt_d = cycles_i;
                    if (cycles_i == '0) begin
                        state_d = SLOT_EXPIRED;
                    end else begin
                        state_d = SLOT_COUNTING;
                    end
                end
            end
            SLOT_COUNTING: begin
                if (cnt_q > 1) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    cnt_d   = '0;
                    state_d = SLOT_EXPIRED;
                end
            end
            SLOT_EXPIRED: begin
                if (retire_i) begin
                    state_d = SLOT_FREE;
                end
            end
            default: begin
                state_d = SLOT_FREE;
            end
        endcase
    end

    assign is_free_o    = (state_q == SLOT_FREE);
    assign is_expired_o = (state_q == SLOT_EXPIRED);
    assign id_o         = id_q;

endmodule

// File: rtl/simmem_release_scheduler.sv
// Per-ID release enables for the response bank, gated by simulated delays.
// Allocates the lowest free slot per request; retires the lowest matching expired slot per release.
module simmem_release_scheduler
    import simmem_pkg::*;
#(
    parameter int IDWidth    = IDWidthDef,
    parameter int NumSlots   = NumSlotsDef,
    parameter int DelayWidth = DelayWidthDef
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    simmem_release_scheduler_if.slave       req_if,
    output logic [2**IDWidth-1:0]           release_en_o,
    output logic [$clog2(NumSlots+1)-1:0]   free_slots_o,
    output logic                            err_o
);

    localparam int CntW = $clog2(NumSlots + 1);

    logic [NumSlots-1:0] free_vec;
    logic [NumSlots-1:0] exp_vec;
    logic [NumSlots-1:0] alloc_vec;
    logic [NumSlots-1:0] retire_vec;
    logic [IDWidth-1:0]  slot_id [NumSlots];

    logic            accept;
    logic            retire_any;
    logic            alloc_taken;
    logic            retire_taken;
    logic [CntW-1:0] free_slots_q, free_slots_d;
    logic            err_q, err_d;

    for (genvar g = 0; g < NumSlots; g++) begin : g_slot
        simmem_release_slot #(
            .IDWidth    (IDWidth),
            .DelayWidth (DelayWidth)
        ) u_slot (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .alloc_i      (alloc_vec[g]),
            .retire_i     (retire_vec[g]),
            .id_i         (req_if.delay_id),
            .cycles_i     (req_if.delay_cycles),
            .is_free_o    (free_vec[g]),
            .is_expired_o (exp_vec[g]),
            .id_o         (slot_id[g])
        );
    end

    assign req_if.delay_ready = |free_vec;
    assign accept = req_if.delay_valid && req_if.delay_ready;

    // Lowest-index free slot takes an accepted request.
    always_comb begin
        alloc_vec   = '0;
        alloc_taken = 1'b0;
        for (int i = 0; i < NumSlots; i++) begin
            if (free_vec[i] && !alloc_taken) begin
                alloc_vec[i] = accept;
                alloc_taken  = 1'b1;
            end
        end
    end

    // Lowest-index expired slot holding the released ID is retired.
    always_comb begin
        retire_vec   = '0;
        retire_taken = 1'b0;
        for (int i = 0; i < NumSlots; i++) begin
            if (exp_vec[i] && (slot_id[i] == req_if.released_id)
                && !retire_taken) begin
                retire_vec[i] = req_if.released_valid;
                retire_taken  = 1'b1;
            end
        end
    end

    assign retire_any = |retire_vec;

    // Release enable per ID: any expired slot carrying that ID.
    always_comb begin
        release_en_o = '0;
        for (int i = 0; i < NumSlots; i++) begin
            if (exp_vec[i]) begin
                release_en_o[slot_id[i]] = 1'b1;
            end
        end
    end

    // Free-slot count tracks allocations and retirements; error is sticky.
    always_comb begin
        free_slots_d = free_slots_q;
        if (accept && !retire_any) begin
            free_slots_d = free_slots_q - 1'b1;
        end else if (retire_any && !accept) begin
            free_slots_d = free_slots_q + 1'b1;
        end
        err_d = err_q;
        if (req_if.released_valid && !retire_taken) begin
            err_d = 1'b1;
        end
    end

    // Count and error registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            free_slots_q <= CntW'(NumSlots);
            err_q        <= 1'b0;
        end else begin
            free_slots_q <= free_slots_d;
            err_q        <= err_d;
        end
    end

    assign free_slots_o = free_slots_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_simmem_release_scheduler.sv
// Directed bench for the release scheduler with a cycle-tagged scoreboard.
// Stimulus queues expected output values; a negedge monitor checks them.
module tb_simmem_release_scheduler;

    localparam int K_BIT  = 0;
    localparam int K_VEC  = 1;
    localparam int K_RDY  = 2;
    localparam int K_FREE = 3;
    localparam int K_ERR  = 4;

    typedef struct {
        int           cyc;
        int           kind;
        int           idx;
        logic [255:0] val;
        string        nm;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] rel;
    logic [4:0]   free_slots;
    logic         err;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    bit   flush = 1'b0;
    exp_t sb[$];
    logic [255:0] mon_act;
    logic [255:0] v;

    simmem_release_scheduler_if #(.IDWidth(8), .DelayWidth(8)) bus ();

    simmem_release_scheduler #(
        .IDWidth    (8),
        .NumSlots   (16),
        .DelayWidth (8)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_if       (bus.slave),
        .release_en_o (rel),
        .free_slots_o (free_slots),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (flush || sb[i].cyc < cyc) begin
                n_vec = n_vec + 1;
                n_bad = n_bad + 1;
                $display("FAIL %s not checked at cycle %0d", sb[i].nm, sb[i].cyc);
                sb.delete(i);
            end else if (sb[i].cyc == cyc) begin
                mon_act = '0;
                case (sb[i].kind)
                    K_BIT:   mon_act[0]   = rel[sb[i].idx];
                    K_VEC:   mon_act      = rel;
                    K_RDY:   mon_act[0]   = bus.delay_ready;
                    K_FREE:  mon_act[4:0] = free_slots;
                    default: mon_act[0]   = err;
                endcase
                n_vec = n_vec + 1;
                if (mon_act !== sb[i].val) begin
                    n_bad = n_bad + 1;
                    $display("FAIL %s cycle %0d got %0h want %0h",
                             sb[i].nm, cyc, mon_act, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) tick();
    endtask

    task automatic push(input int c, input int k, input int idx,
                        input logic [255:0] val, input string nm);
        exp_t e;
        e.cyc  = c;
        e.kind = k;
        e.idx  = idx;
        e.val  = val;
        e.nm   = nm;
        sb.push_back(e);
    endtask

    task automatic req(input bit vld, input int id, input int d);
        bus.delay_valid  = vld;
        bus.delay_id     = 8'(id);
        bus.delay_cycles = 8'(d);
    endtask

    task automatic rls(input bit vld, input int id);
        bus.released_valid = vld;
        bus.released_id    = 8'(id);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        push(cyc, K_VEC,  0, '0, "rst_rel");
        push(cyc, K_RDY,  0, 1,  "rst_ready");
        push(cyc, K_FREE, 0, 16, "rst_free");
        push(cyc, K_ERR,  0, 0,  "rst_err");
    endtask

    initial begin : stim
        int t;
        rst = 1'b1;
        req(0, 0, 0);
        rls(0, 0);
        tick();
        reset_dut();

        // accept id3 D5, release at +8
        t = cyc;
        req(1, 3, 5);
        for (int k = 1; k <= 5; k++) push(t + k, K_BIT, 3, 0, "t1_early");
        push(t + 1, K_FREE, 0, 15, "t1_free");
        push(t + 6, K_BIT, 3, 1, "t1_expire");
        push(t + 8, K_BIT, 3, 1, "t1_hold");
        push(t + 9, K_BIT, 3, 0, "t1_retired");
        push(t + 9, K_FREE, 0, 16, "t1_free_back");
        push(t + 9, K_ERR, 0, 0, "t1_err");
        tick();
        req(0, 0, 0);
        goto(t + 8);
        rls(1, 3);
        tick();
        rls(0, 0);

        // zero delay
        t = cyc;
        v = '0;
        v[7] = 1'b1;
        req(1, 7, 0);
        push(t + 1, K_BIT, 7, 1, "t2_zero");
        push(t + 1, K_VEC, 0, v, "t2_only7");
        push(t + 2, K_VEC, 0, '0, "t2_clear");
        push(t + 2, K_FREE, 0, 16, "t2_free");
        tick();
        req(0, 0, 0);
        rls(1, 7);
        tick();
        rls(0, 0);

        // fill, hold 17th, then simultaneous accept/retire
        t = cyc;
        push(t + 15, K_RDY, 0, 1, "t3_one_left");
        push(t + 15, K_FREE, 0, 1, "t3_free1");
        push(t + 16, K_RDY, 0, 0, "t3_full_rdy");
        push(t + 16, K_FREE, 0, 0, "t3_full_free");
        push(t + 17, K_RDY, 0, 0, "t3_held_rdy");
        push(t + 201, K_RDY, 0, 0, "t3_late_rdy");
        push(t + 200, K_BIT, 20, 0, "t3_pre_exp");
        push(t + 201, K_BIT, 20, 1, "t3_exp");
        push(t + 202, K_RDY, 0, 1, "t3_freed_rdy");
        push(t + 202, K_FREE, 0, 1, "t3_freed_cnt");
        push(t + 203, K_RDY, 0, 0, "t3_took17");
        push(t + 203, K_FREE, 0, 0, "t3_free0");
        push(t + 203, K_BIT, 50, 1, "t3_id50");
        push(t + 204, K_RDY, 0, 1, "t5_rdy_after");
        push(t + 204, K_FREE, 0, 1, "t5_free1");
        push(t + 205, K_FREE, 0, 1, "t5_both_free");
        push(t + 205, K_RDY, 0, 1, "t5_both_rdy");
        push(t + 205, K_BIT, 60, 1, "t5_id60");
        push(t + 205, K_BIT, 21, 0, "t5_id21");
        push(t + 205, K_BIT, 50, 0, "t5_id50");
        push(t + 205, K_ERR, 0, 0, "t5_err");
        for (int i = 0; i < 16; i++) begin
            req(1, 20 + i, 200);
            tick();
        end
        req(1, 50, 0);
        goto(t + 201);
        rls(1, 20);
        tick();
        rls(0, 0);
        goto(t + 203);
        req(1, 60, 0);
        rls(1, 50);
        tick();
        rls(1, 21);
        tick();
        req(0, 0, 0);
        rls(0, 0);
        tick();

        // two of one ID, count-based release, then error
        reset_dut();
        t = cyc;
        req(1, 2, 10);
        push(t + 2, K_BIT, 2, 0, "t4_pre");
        push(t + 3, K_BIT, 2, 1, "t4_first");
        push(t + 3, K_FREE, 0, 14, "t4_free14");
        push(t + 4, K_BIT, 2, 0, "t4_gap");
        push(t + 4, K_FREE, 0, 15, "t4_free15");
        push(t + 10, K_BIT, 2, 0, "t4_gap_end");
        push(t + 11, K_BIT, 2, 1, "t4_second");
        push(t + 12, K_BIT, 2, 0, "t4_done");
        push(t + 12, K_FREE, 0, 16, "t4_free16");
        push(t + 12, K_ERR, 0, 0, "t4_no_err");
        push(t + 13, K_ERR, 0, 1, "t4_err");
        push(t + 13, K_FREE, 0, 16, "t4_err_free");
        push(t + 16, K_ERR, 0, 1, "t4_err_sticky");
        tick();
        req(1, 2, 1);
        tick();
        req(0, 0, 0);
        goto(t + 3);
        rls(1, 2);
        tick();
        rls(0, 0);
        goto(t + 11);
        rls(1, 2);
        tick();
        tick();
        rls(0, 0);
        goto(t + 17);

        // reset mid-countdown
        reset_dut();
        t = cyc;
        push(t + 5, K_FREE, 0, 11, "t6_five");
        push(t + 5, K_BIT, 9, 0, "t6_counting");
        push(t + 6, K_VEC, 0, '0, "t6_rel");
        push(t + 6, K_FREE, 0, 16, "t6_free");
        push(t + 6, K_ERR, 0, 0, "t6_err");
        push(t + 6, K_RDY, 0, 1, "t6_rdy");
        push(t + 30, K_VEC, 0, '0, "t6_no_expiry");
        push(t + 30, K_FREE, 0, 16, "t6_free_late");
        for (int i = 0; i < 5; i++) begin
            req(1, 9 + i, 20);
            tick();
        end
        req(0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        goto(t + 32);

        flush = 1'b1;
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
